shifter_seq: RTL and testbench

Parametrised multi-cycle shift unit. It generalises the fixed 4-bit combinational logical-right shifter to WIDTH bits, four shift modes and a per-cycle step size STEP. Operands are accepted over a valid/ready handshake, shifted iteratively under a small FSM, and the result is held on a valid/ready output port. It sits in the catalog as the sequential shift element for datapath and ALU experiments.

---
 rtl/shifter_seq_if.sv | 27 ++
 rtl/shifter_seq.sv | 104 ++++++++++
 tb/tb_shifter_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_seq_if.sv
// Operand/result port bundle for shifter_seq.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds its payload stable until then, and neither ready depends combinationally on valid.
interface shifter_seq_if #(
   parameter int WIDTH = 8
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [SHW-1:0]   shamt;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;

   modport master (
      output in_valid, a, shamt, mode, out_ready,
      input  in_ready, out_valid, c
   );

   modport slave (
      input  in_valid, a, shamt, mode, out_ready,
      output in_ready, out_valid, c
   );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: SRL/SLL/SRA/ROR of a WIDTH-bit operand, up to STEP positions per cycle.
// state_dbg exposes the FSM (0 IDLE, 1 SHIFT, 2 DONE).
module shifter_seq #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   shifter_seq_if.slave bus,
   output logic        busy,
   output logic [1:0]  state_dbg
);
   localparam int SHW   = $clog2(WIDTH);
   // No single step can exceed the largest legal shamt, so clamp to fit the counter width.
   localparam int STEPC = (STEP < WIDTH) ? STEP : WIDTH - 1;
   localparam logic [SHW:0] WV = (SHW + 1)'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] c_r;
   logic [SHW-1:0]   cnt;
   logic [1:0]       mode_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   logic [SHW-1:0]   s;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      s   = (cnt < SHW'(STEPC)) ? cnt : SHW'(STEPC);
      nxt = c_r;
      case (mode_r)
         2'b00:   nxt = c_r >> s;
         2'b01:   nxt = c_r << s;
         // The register MSB still holds the original sign, so an arithmetic step preserves it.
         2'b10:   nxt = $signed(c_r) >>> s;
         default: nxt = (c_r >> s) | (c_r << (WV - {1'b0, s}));
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         c_r         <= '0;
         cnt         <= '0;
         mode_r      <= 2'b00;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  c_r        <= bus.a;
                  cnt        <= bus.shamt;
                  mode_r     <= bus.mode;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  if (bus.shamt == '0) begin
                     state       <= DONE;
                     out_valid_r <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               c_r <= nxt;
               cnt <= cnt - s;
               if (cnt == s) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.c         = c_r;
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign busy          = busy_r;
   assign state_dbg     = state;
endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: seven lanes of differing WIDTH/STEP share one clock and reset;
// directed scenarios run on lanes 0 (8,1) and 1 (8,3), the random sweep on every lane.
module tb_shifter_seq;
   localparam int NL = 7;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic int lane_w(input int g);
      case (g)
         0, 1, 2, 3: return 8;
         default:    return 16;
      endcase
   endfunction

   function automatic int lane_s(input int g);
      case (g)
         0: return 1;
         1: return 3;
         2: return 2;
         3: return 8;
         4: return 1;
         5: return 2;
         default: return 16;
      endcase
   endfunction

   // Independent bit-level reference of a single combinational shift.
   function automatic logic [15:0] ref_shift(input logic [15:0] v, input int sh,
                                             input logic [1:0] md, input int w);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (md)
            2'b00:   r[i] = (i + sh < w) ? v[i + sh] : 1'b0;
            2'b01:   r[i] = (i >= sh) ? v[i - sh] : 1'b0;
            2'b10:   r[i] = (i + sh < w) ? v[i + sh] : v[w - 1];
            default: r[i] = v[(i + sh) % w];
         endcase
      end
      return r;
   endfunction

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- lanes ----------------
   logic        in_valid_l  [NL];
   logic [15:0] a_l         [NL];
   logic [3:0]  shamt_l     [NL];
   logic [1:0]  mode_l      [NL];
   logic        out_ready_l [NL];

   logic [NL*16-1:0] c_v;
   logic [NL-1:0]    ov_v;
   logic [NL-1:0]    ir_v;
   logic [NL-1:0]    busy_v;
   logic [NL*2-1:0]  st_v;

   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int W  = lane_w(g);
      localparam int S  = lane_s(g);
      localparam int SW = $clog2(W);

      shifter_seq_if #(.WIDTH(W)) bus ();

      assign bus.in_valid  = in_valid_l[g];
      assign bus.a         = a_l[g][W-1:0];
      assign bus.shamt     = shamt_l[g][SW-1:0];
      assign bus.mode      = mode_l[g];
      assign bus.out_ready = out_ready_l[g];
      assign c_v[g*16 +: 16] = 16'(bus.c);
      assign ov_v[g] = bus.out_valid;
      assign ir_v[g] = bus.in_ready;

      shifter_seq #(.WIDTH(W), .STEP(S)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .bus       (bus),
         .busy      (busy_v[g]),
         .state_dbg (st_v[g*2 +: 2])
      );
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   // ---------------- driver tasks ----------------
   // Starts at posedge+1; returns at posedge+1 with the lane back in IDLE.
   task automatic run_op(input int ln, input logic [15:0] av, input int sh,
                         input logic [1:0] md, input logic [15:0] ex, input bit rnd);
      int n;
      int lat_exp;
      int stall;
      logic [15:0] got;
      logic [15:0] want;
      lat_exp = (sh + lane_s(ln) - 1) / lane_s(ln);
      n_cmp++;
      if (ir_v[ln] !== 1'b1) begin
         n_err++;
         $display("FAIL op_idle lane%0d: in_ready=%b required 1", ln, ir_v[ln]);
      end
      exp_q.push_back(ex);
      a_l[ln] = av;
      shamt_l[ln] = sh[3:0];
      mode_l[ln] = md;
      in_valid_l[ln] = 1'b1;
      out_ready_l[ln] = 1'b0;
      @(posedge clk); #1;
      // Scramble the operand lines after accept; the operation in flight must ignore them.
      in_valid_l[ln] = 1'b0;
      a_l[ln] = 16'($urandom);
      shamt_l[ln] = 4'($urandom);
      mode_l[ln] = 2'($urandom);
      n = 0;
      while (ov_v[ln] !== 1'b1 && n < 64) begin
         n_cmp++;
         if (busy_v[ln] !== 1'b1 || ir_v[ln] !== 1'b0 || st_v[ln*2 +: 2] !== ST_SHIFT) begin
            n_err++;
            $display("FAIL shift_phase lane%0d: busy=%b in_ready=%b state=%0d required 1/0/%0d",
                     ln, busy_v[ln], ir_v[ln], st_v[ln*2 +: 2], ST_SHIFT);
         end
         out_ready_l[ln] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         n++;
      end
      out_ready_l[ln] = 1'b0;
      want = exp_q.pop_front();
      n_cmp++;
      if (ov_v[ln] !== 1'b1) begin
         n_err++;
         $display("FAIL timeout lane%0d: out_valid=%b after %0d cycles, required 1", ln, ov_v[ln], n);
         return;
      end
      n_cmp++;
      if (n != lat_exp) begin
         n_err++;
         $display("FAIL latency lane%0d sh=%0d: got %0d cycles required %0d", ln, sh, n, lat_exp);
      end
      got = c_v[ln*16 +: 16];
      n_cmp++;
      if (got !== want || busy_v[ln] !== 1'b1 || ir_v[ln] !== 1'b0) begin
         n_err++;
         $display("FAIL result lane%0d a=%h sh=%0d mode=%0d: c=%h busy=%b in_ready=%b required c=%h 1/0",
                  ln, av, sh, md, got, busy_v[ln], ir_v[ln], want);
      end
      stall = rnd ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (ov_v[ln] !== 1'b1 || c_v[ln*16 +: 16] !== want || ir_v[ln] !== 1'b0) begin
            n_err++;
            $display("FAIL hold lane%0d: out_valid=%b c=%h in_ready=%b required 1/%h/0",
                     ln, ov_v[ln], c_v[ln*16 +: 16], ir_v[ln], want);
         end
      end
      out_ready_l[ln] = 1'b1;
      @(posedge clk); #1;
      out_ready_l[ln] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      n_cmp++;
      if (ov_v[ln] !== 1'b0 || ir_v[ln] !== 1'b1 || busy_v[ln] !== 1'b0) begin
         n_err++;
         $display("FAIL release lane%0d: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                  ln, ov_v[ln], ir_v[ln], busy_v[ln]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      for (int g = 0; g < NL; g++) begin
         in_valid_l[g] = 1'b0;
         a_l[g] = '0;
         shamt_l[g] = '0;
         mode_l[g] = '0;
         out_ready_l[g] = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < NL; g++) begin
         n_cmp++;
         if (ir_v[g] !== 1'b1 || ov_v[g] !== 1'b0 || busy_v[g] !== 1'b0 ||
             c_v[g*16 +: 16] !== 16'h0 || st_v[g*2 +: 2] !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset lane%0d: in_ready=%b out_valid=%b busy=%b c=%h state=%0d required 1/0/0/0000/0",
                     g, ir_v[g], ov_v[g], busy_v[g], c_v[g*16 +: 16], st_v[g*2 +: 2]);
         end
      end
      // An accept edge while reset is held must be discarded.
      in_valid_l[0] = 1'b1;
      a_l[0] = 16'h0077;
      shamt_l[0] = 4'd2;
      @(posedge clk); #1;
      n_cmp++;
      if (st_v[1:0] !== ST_IDLE || c_v[15:0] !== 16'h0 || ir_v[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_accept: state=%0d c=%h in_ready=%b required 0/0000/1",
                  st_v[1:0], c_v[15:0], ir_v[0]);
      end
      in_valid_l[0] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_modes();
      logic [15:0] exp_tab [4];
      exp_tab[0] = 16'h16;
      exp_tab[1] = 16'hA0;
      exp_tab[2] = 16'hF6;
      exp_tab[3] = 16'h96;
      for (int m = 0; m < 4; m++) run_op(0, 16'hB4, 3, 2'(m), exp_tab[m], 1'b0);
   endtask

   task automatic test_shamt_zero();
      for (int m = 0; m < 4; m++) run_op(0, 16'h5A, 0, 2'(m), 16'h5A, 1'b0);
   endtask

   task automatic test_step3();
      run_op(1, 16'hFF, 7, 2'b00, 16'h01, 1'b0);
      run_op(1, 16'h80, 7, 2'b10, 16'hFF, 1'b0);
      run_op(1, 16'hB4, 4, 2'b11, 16'h4B, 1'b0);
   endtask

   task automatic test_backpressure();
      int n;
      exp_q.push_back(16'h2D);
      a_l[0] = 16'hB4;
      shamt_l[0] = 4'd2;
      mode_l[0] = 2'b00;
      in_valid_l[0] = 1'b1;
      out_ready_l[0] = 1'b0;
      @(posedge clk); #1;
      in_valid_l[0] = 1'b0;
      n = 0;
      while (ov_v[0] !== 1'b1 && n < 16) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (ov_v[0] !== 1'b1 || c_v[15:0] !== exp_q[0]) begin
         n_err++;
         $display("FAIL bp_result: out_valid=%b c=%h required 1/%h", ov_v[0], c_v[15:0], exp_q[0]);
      end
      // New operand offered while the result is stalled.
      in_valid_l[0] = 1'b1;
      a_l[0] = 16'h11;
      shamt_l[0] = 4'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (ov_v[0] !== 1'b1 || c_v[15:0] !== exp_q[0] || ir_v[0] !== 1'b0 || st_v[1:0] !== ST_DONE) begin
            n_err++;
            $display("FAIL bp_hold cycle%0d: out_valid=%b c=%h in_ready=%b state=%0d required 1/%h/0/%0d",
                     i, ov_v[0], c_v[15:0], ir_v[0], st_v[1:0], exp_q[0], ST_DONE);
         end
      end
      void'(exp_q.pop_front());
      exp_q.push_back(16'h11);
      out_ready_l[0] = 1'b1;
      @(posedge clk); #1;
      out_ready_l[0] = 1'b0;
      n_cmp++;
      if (st_v[1:0] !== ST_IDLE || ir_v[0] !== 1'b1 || ov_v[0] !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: state=%0d in_ready=%b out_valid=%b required 0/1/0",
                  st_v[1:0], ir_v[0], ov_v[0]);
      end
      @(posedge clk); #1;
      in_valid_l[0] = 1'b0;
      n_cmp++;
      if (ov_v[0] !== 1'b1 || c_v[15:0] !== exp_q[0]) begin
         n_err++;
         $display("FAIL bp_next: out_valid=%b c=%h required 1/%h", ov_v[0], c_v[15:0], exp_q[0]);
      end
      void'(exp_q.pop_front());
      out_ready_l[0] = 1'b1;
      @(posedge clk); #1;
      out_ready_l[0] = 1'b0;
   endtask

   task automatic test_back_to_back();
      in_valid_l[0] = 1'b1;
      shamt_l[0] = 4'd0;
      out_ready_l[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_l[0] = 16'($urandom_range(0, 255));
         mode_l[0] = 2'($urandom);
         exp_q.push_back(a_l[0]);
         @(posedge clk); #1;
         n_cmp++;
         if (ov_v[0] !== 1'b1 || c_v[15:0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL b2b_done op%0d: out_valid=%b c=%h required 1/%h", i, ov_v[0], c_v[15:0], exp_q[0]);
         end
         void'(exp_q.pop_front());
         @(posedge clk); #1;
         n_cmp++;
         if (ov_v[0] !== 1'b0 || ir_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle op%0d: out_valid=%b in_ready=%b required 0/1", i, ov_v[0], ir_v[0]);
         end
      end
      in_valid_l[0] = 1'b0;
      out_ready_l[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_l[0] = 16'hF0;
      shamt_l[0] = 4'd6;
      mode_l[0] = 2'b00;
      in_valid_l[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_l[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      n_cmp++;
      if (st_v[1:0] !== ST_SHIFT) begin
         n_err++;
         $display("FAIL rst_mid_pre: state=%0d required %0d", st_v[1:0], ST_SHIFT);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ov_v[0] !== 1'b0 || c_v[15:0] !== 16'h0 || busy_v[0] !== 1'b0 || ir_v[0] !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid: out_valid=%b c=%h busy=%b in_ready=%b required 0/0000/0/1",
                  ov_v[0], c_v[15:0], busy_v[0], ir_v[0]);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(0, 16'h80, 1, 2'b00, 16'h40, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] av;
      logic [15:0] mask;
      logic [1:0]  md;
      int          sh;
      int          w;
      for (int ln = 0; ln < NL; ln++) begin
         w = lane_w(ln);
         mask = (w == 16) ? 16'hFFFF : 16'h00FF;
         for (int k = 0; k < 30; k++) begin
            av = 16'($urandom) & mask;
            sh = (k < 4) ? ((k == 0) ? 0 : w - 1) : $urandom_range(0, w - 1);
            md = (k < 4) ? 2'(k) : 2'($urandom);
            run_op(ln, av, sh, md, ref_shift(av, sh, md, w), 1'b1);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_modes();
      test_shamt_zero();
      test_step3();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
